// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus DEPTH-entry instruction queue
// feeding the IF/ID boundary, with redirect flush and wait states.
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [DATA_W-1:0]            inst_adr,
  output logic                         inst_req,
  input  logic [DATA_W-1:0]            inst,
  input  logic                         inst_valid,
  input  logic                         redirect,
  input  logic [DATA_W-1:0]            redirect_adr,
  input  logic                         IFID_Ld,
  output logic [DATA_W-1:0]            IFIDinst_out,
  output logic [DATA_W-1:0]            IFIDadder1_out,
  output logic                         IFID_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0]   pc4;
  logic [DATA_W-1:0]   tgt;
  logic                full, valid;
  logic                pop, push;
  logic                unused_adr;

  // Low target bits are forced to word alignment.
  assign unused_adr = ^redirect_adr[1:0];
  assign tgt = {redirect_adr[DATA_W-1:2], 2'b00};

  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign pc4   = pc_q + DATA_W'(4);

  // A full queue still accepts a word when the head leaves.
  assign pop      = IFID_Ld & valid & ~redirect;
  assign inst_req = ~redirect & (~full | pop);
  assign push     = inst_req & inst_valid;

  assign head           = mem_q[rd_ptr_q];
  assign IFIDinst_out   = head[2*DATA_W-1:DATA_W]
                          & {DATA_W{valid}};
  assign IFIDadder1_out = head[DATA_W-1:0]
                          & {DATA_W{valid}};
  assign IFID_valid     = valid;
  assign inst_adr       = pc_q;
  assign count          = count_q;

  // Next PC, pointers and occupancy; reset beats redirect.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rst) begin
      pc_d     = RESET_PC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (redirect) begin
      pc_d     = tgt;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

  // Queue storage; contents are masked while empty, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {inst, pc4};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a
// queue-based reference model of the fetch stage.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_adr;
  logic        inst_req;
  logic [31:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_adr = '0;
  logic        IFID_Ld = 1'b0;
  logic [31:0] IFIDinst_out;
  logic [31:0] IFIDadder1_out;
  logic        IFID_valid;
  logic [2:0]  count;

  logic [31:0] w_adr;
  logic        w_req;
  logic [31:0] w_inst_out;
  logic [31:0] w_pc4_out;
  logic        w_valid;
  logic [2:0]  w_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .inst_adr(inst_adr), .inst_req(inst_req),
    .inst(inst), .inst_valid(inst_valid),
    .redirect(redirect), .redirect_adr(redirect_adr),
    .IFID_Ld(IFID_Ld),
    .IFIDinst_out(IFIDinst_out),
    .IFIDadder1_out(IFIDadder1_out),
    .IFID_valid(IFID_valid), .count(count)
  );

  fetch_queue #(.DATA_W(32), .DEPTH(DEPTH),
                .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .inst_adr(w_adr), .inst_req(w_req),
    .inst(32'h1234_5678), .inst_valid(1'b1),
    .redirect(1'b0), .redirect_adr(32'h0),
    .IFID_Ld(1'b0),
    .IFIDinst_out(w_inst_out),
    .IFIDadder1_out(w_pc4_out),
    .IFID_valid(w_valid), .count(w_count)
  );

  typedef struct {
    logic [31:0] i;
    logic [31:0] p4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = '0;
  bit          m_init = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: advance on each rising edge.
  always @(posedge clk) begin
    bit pp, rq, ps;
    if (rst) begin
      mq.delete();
      m_pc = 32'h0;
      m_init = 1;
    end else if (m_init) begin
      if (redirect) begin
        mq.delete();
        m_pc = redirect_adr & 32'hFFFF_FFFC;
      end else begin
        pp = IFID_Ld && (mq.size() > 0);
        rq = (mq.size() < DEPTH) || pp;
        ps = rq && inst_valid;
        if (pp) void'(mq.pop_front());
        if (ps) begin
          mq.push_back('{i: inst, p4: m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Compare every DUT output against the model each cycle.
  always @(negedge clk) begin
    bit pe, re, ne;
    logic [31:0] hi, hp;
    #1;
    if (m_init) begin
      ne = mq.size() > 0;
      pe = IFID_Ld && ne && !redirect;
      re = !redirect && ((mq.size() < DEPTH) || pe);
      hi = ne ? mq[0].i  : 32'h0;
      hp = ne ? mq[0].p4 : 32'h0;
      chk("inst_adr", inst_adr, m_pc);
      chk("inst_req", 32'(inst_req), 32'(re));
      chk("IFID_valid", 32'(IFID_valid), 32'(ne));
      chk("IFIDinst_out", IFIDinst_out, hi);
      chk("IFIDadder1_out", IFIDadder1_out, hp);
      chk("count", 32'(count), 32'(mq.size()));
    end
  end

  task automatic drive(input bit r, input bit rd,
                       input logic [31:0] ra,
                       input bit ld, input bit v);
    @(negedge clk);
    rst = r;
    redirect = rd;
    redirect_adr = ra;
    IFID_Ld = ld;
    inst_valid = v;
    inst = m_pc | 32'hA000_0000;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] ra;

    // Reset state
    do_reset();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("rst inst_adr", inst_adr, 32'h0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst valid", 32'(IFID_valid), 32'd0);
    chk("rst inst_out", IFIDinst_out, 32'h0);
    chk("rst inst_req", 32'(inst_req), 32'd1);
    chk("wrap rst adr", w_adr, 32'hFFFF_FFFC);

    // Streaming at one word per cycle
    drive(0, 0, 0, 1, 1);
    #2;
    chk("wrap pc4", w_pc4_out, 32'h0);
    chk("wrap inst", w_inst_out, 32'h1234_5678);
    chk("wrap next adr", w_adr, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 1, 1);
      #2;
      chk("stream pc4", IFIDadder1_out, 32'(4 * k));
      chk("stream count", 32'(count), 32'd1);
    end

    // Fill and stall
    do_reset();
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    #2;
    chk("fill count", 32'(count), 32'd4);
    chk("fill req", 32'(inst_req), 32'd0);
    chk("fill adr", inst_adr, 32'h10);
    drive(0, 0, 0, 1, 1);
    #2;
    chk("fill pop req", 32'(inst_req), 32'd1);
    drive(0, 0, 0, 0, 1);
    #2;
    chk("pp count", 32'(count), 32'd4);
    chk("pp adr", inst_adr, 32'h14);
    chk("pp head", IFIDadder1_out, 32'h8);

    // Redirect from a full queue
    drive(0, 1, 32'h43, 1, 1);
    drive(0, 0, 0, 0, 1);
    #2;
    chk("redir count", 32'(count), 32'd0);
    chk("redir valid", 32'(IFID_valid), 32'd0);
    chk("redir adr", inst_adr, 32'h40);
    drive(0, 0, 0, 0, 1);
    #2;
    chk("redir pc4", IFIDadder1_out, 32'h44);
    chk("redir inst", IFIDinst_out, 32'hA000_0040);

    // Wait states drain the queue while PC holds
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    #2;
    chk("wait valid", 32'(IFID_valid), 32'd0);
    chk("wait inst", IFIDinst_out, 32'h0);
    chk("wait adr", inst_adr, 32'h48);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    #2;
    chk("resume adr", inst_adr, 32'h4C);
    chk("resume pc4", IFIDadder1_out, 32'h4C);

    // Random traffic, including redirects near the top of memory
    for (int n = 0; n < 800; n++) begin
      ra = ($urandom_range(0, 3) == 0)
           ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
           : $urandom;
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 15) == 0, ra,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0);
    end

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage for the MIPS pipeline, replacing the single PC register plus IF/ID latch with a PC generator and a DEPTH-entry instruction queue. It issues sequential fetch addresses to instruction memory, tolerates memory wait states through `inst_valid`, and buffers fetched {instruction, PC+4} pairs for the decode stage. Branch and jump redirects from the pc_src logic flush the queue and restart fetch at the target. The IF/ID-facing outputs keep the existing pipeline signal names, so the hazard unit (`IFID_Ld`) and the controller connect unchanged.

## Interface
Parameters:
- `DATA_W`, 32: instruction and address width.
- `DEPTH`, 4: queue entries. Power of 2, at least 2.
- `RESET_PC`, 0: fetch address after reset. Word-aligned.

Ports:
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_adr`  out  DATA_W  current fetch PC, driven to instruction memory.
- `inst_req`  out  1  fetch request; the queue accepts a word this cycle.
- `inst`  in  DATA_W  instruction memory read data for `inst_adr`.
- `inst_valid`  in  1  `inst` is valid this cycle. Low means a memory wait state.
- `redirect`  in  1  taken branch or jump: flush the queue and load the new PC.
- `redirect_adr`  in  DATA_W  redirect target. Bits [1:0] are ignored and forced to 0.
- `IFID_Ld`  in  1  decode consumes the head entry (hazard unit stall = 0).
- `IFIDinst_out`  out  DATA_W  head instruction. 0 (nop) when the queue is empty.
- `IFIDadder1_out`  out  DATA_W  head PC+4. 0 when the queue is empty.
- `IFID_valid`  out  1  queue is non-empty.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
State:
- `pc`: DATA_W bits.
- Queue: DEPTH × 2·DATA_W, holding {inst, pc4} per entry.
- `rd_ptr`, `wr_ptr`: $clog2(DEPTH) bits each. Both wrap modulo DEPTH.
- `count`.

Derived signals:
- `pop` = `IFID_Ld` & `IFID_valid` & ~`redirect`.
- `inst_req` = ~`redirect` & ((`count` < DEPTH) | `pop`).
- `push` = `inst_req` & `inst_valid`.

Each cycle, in priority order:
1. `rst`:
   - `pc` ← RESET_PC.
   - `rd_ptr`, `wr_ptr`, `count` ← 0.
   - Queue contents are don't-care, because the head outputs are masked to 0 while empty.
2. `redirect`:
   - `pc` ← {`redirect_adr`[DATA_W-1:2], 2'b00}.
   - Pointers and `count` ← 0.
   - No push and no pop, regardless of `IFID_Ld` and `inst_valid`.
3. Otherwise:
   - On `push`: write {`inst`, `pc`+4} at `wr_ptr`, then `wr_ptr`++ and `pc` ← `pc`+4.
   - On `pop`: `rd_ptr`++.
   - `count` += `push` − `pop`.

Rules:
- PC+4 wraps modulo 2^DATA_W (0xFFFFFFFC + 4 = 0).
- When full, a push is allowed only in a cycle that also pops; `count` stays at DEPTH.
- Pop on empty is impossible by construction (`pop` is gated by `IFID_valid`).
- The head outputs are combinational from the entry at `rd_ptr`, ANDed with `IFID_valid`.
- `inst_adr` = `pc` (registered).
- The block has no FSM; the state is `pc`, the two pointers and `count`.

## Timing
- Reset values:
  - `inst_adr` = RESET_PC.
  - `inst_req` = 1 (when `redirect` is low).
  - `IFID_valid` = 0, `IFIDinst_out` = 0, `IFIDadder1_out` = 0, `count` = 0.
- Fetch-to-decode latency is 1 cycle. A word pushed in cycle N is visible at the head in N+1 if the queue was empty. There is no same-cycle bypass.
- Steady-state throughput is 1 instruction per cycle when `inst_valid` = 1 and `IFID_Ld` = 1.
- Redirect penalty:
  - The target is fetched in the cycle after `redirect`.
  - It reaches decode 2 cycles after `redirect`.
  - `IFID_valid` is 0 in the cycle immediately after `redirect`.
- A wait state (`inst_valid` = 0) holds `pc`. The same address is re-presented until accepted.
- `inst_req` depends combinationally on `IFID_Ld` and `redirect` only, never on `inst_valid`, so there is no combinational loop with memory.
- `rst` asserted mid-stream overrides a simultaneous `redirect`, push and pop.

## Test plan
- **Reset.** `rst` high for 2 cycles → `inst_adr` = 0x0, `count` = 0, `IFID_valid` = 0, `IFIDinst_out` = 0, `inst_req` = 1.
- **Streaming.** `inst_valid` = 1, `IFID_Ld` = 1, memory returns `inst` = `adr`|0xA000_0000 → from cycle 2, one entry per cycle; `IFIDadder1_out` = 4, 8, 12, …; `count` holds at 1.
- **Fill and stall** (DEPTH = 4).
  - With `IFID_Ld` = 0: after 4 fetches `count` = 4, `inst_req` = 0, `inst_adr` holds 0x10.
  - Then one cycle of `IFID_Ld` = 1: a simultaneous push and pop leave `count` at 4, `inst_adr` goes to 0x14, and the head advances to pc4 = 8.
- **Redirect.** Queue full, `IFID_Ld` = 1, `inst_valid` = 1, `redirect` = 1, `redirect_adr` = 0x43 → next cycle `count` = 0, `IFID_valid` = 0, `inst_adr` = 0x40. The following cycle the head shows pc4 = 0x44.
- **Wait states.** `inst_valid` low for 3 cycles while `IFID_Ld` = 1 → `inst_adr` is constant, the queue drains to `IFID_valid` = 0 with `IFIDinst_out` = 0, and fetch resumes on the first `inst_valid` = 1.
- **Wrap.** RESET_PC = 0xFFFFFFFC → the first entry has pc4 = 0x0 and the next `inst_adr` = 0x0. The pointers wrap correctly through 3×DEPTH pushes and pops, checked against a scoreboard.
